// File: rtl/eg4_rst_seq_pkg.sv
// Shared constants, state encoding and helpers for the EG4S20 reset sequencer.
package eg4_rst_seq_pkg;

  localparam int CONFIG_OSC_CLOCK = 50000000;
  localparam int HZ_PER_MHZ       = 1000000;
  localparam int US_PER_MS        = 1000;

  typedef enum logic [2:0] {
    ST_PWR = 3'd0,
    ST_SYS = 3'd1,
    ST_RUN = 3'd2,
    ST_SFT = 3'd3,
    ST_BTN = 3'd4
  } rst_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/eg4_rst_seq_tick_gen.sv
// Free-running microsecond / millisecond strobe generator, shared by the board tops.
module rst_tick_gen
  import eg4_rst_seq_pkg::*;
#(
  parameter int CLK_HZ = CONFIG_OSC_CLOCK
) (
  input  logic sys_clk_p,
  input  logic pwr_rst_n,
  output logic sys_us,
  output logic sys_ms
);

  localparam int US_DIV = CLK_HZ / HZ_PER_MHZ;
  localparam int US_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int MS_W   = $clog2(US_PER_MS);

  localparam logic [US_W-1:0] US_LAST = US_W'(US_DIV - 1);
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(US_PER_MS - 1);

  if (US_DIV < 2) begin : g_bad_div
    $error("rst_tick_gen: CLK_HZ must give at least 2 clocks per microsecond");
  end
  if ((CLK_HZ % HZ_PER_MHZ) != 0) begin : g_bad_hz
    $error("rst_tick_gen: CLK_HZ must be a whole number of MHz");
  end

  logic [US_W-1:0] us_cnt, us_nxt;
  logic [MS_W-1:0] ms_cnt, ms_nxt;

  // Next counter values; strobes are registered from these so they line up with the counts.
  always_comb begin
    us_nxt = (us_cnt == US_LAST) ? '0 : us_cnt + 1'b1;
    ms_nxt = ms_cnt;
    if (sys_us) begin
      ms_nxt = (ms_cnt == MS_LAST) ? '0 : ms_cnt + 1'b1;
    end
  end

  // Prescaler registers: sys_us is high while us_cnt sits at its last value,
  // sys_ms on the sys_us that wraps ms_cnt.
  always_ff @(posedge sys_clk_p or negedge pwr_rst_n) begin
    if (!pwr_rst_n) begin
      us_cnt <= '0;
      ms_cnt <= '0;
      sys_us <= 1'b0;
      sys_ms <= 1'b0;
    end else begin
      us_cnt <= us_nxt;
      ms_cnt <= ms_nxt;
      sys_us <= (us_nxt == US_LAST);
      sys_ms <= (us_nxt == US_LAST) && (ms_nxt == MS_LAST);
    end
  end

endmodule

// File: rtl/eg4_rst_seq.sv
// Reset and timebase sequencer: orders power-on / system reset release after PLL lock,
// debounces the board reset button and services CPU soft-reset requests.
module eg4_rst_seq
  import eg4_rst_seq_pkg::*;
#(
  parameter int CLK_HZ  = CONFIG_OSC_CLOCK,
  parameter int PWR_MS  = 4,
  parameter int SYS_MS  = 2,
  parameter int DEB_MS  = 10,
  parameter int SFT_US  = 8,
  parameter int BTN_INV = 1
) (
  input  logic sys_clk_p,
  input  logic pwr_rst_n,
  input  logic ext_reset,
  input  logic cpu_srst,
  output logic sys_us,
  output logic sys_ms,
  output logic pwr_rst,
  output logic sys_rst,
  output logic sys_ready
);

  localparam int HOLD_MAX = max3(PWR_MS, SYS_MS, SFT_US);
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam int DEB_W    = $clog2(DEB_MS + 1);

  localparam logic [HOLD_W-1:0] HOLD_PWR = HOLD_W'(PWR_MS);
  localparam logic [HOLD_W-1:0] HOLD_SYS = HOLD_W'(SYS_MS);
  localparam logic [HOLD_W-1:0] HOLD_SFT = HOLD_W'(SFT_US);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_MS - 1);
  localparam logic              BTN_POL  = (BTN_INV != 0);

  if (PWR_MS == 0 || SYS_MS == 0 || DEB_MS == 0 || SFT_US == 0) begin : g_bad_param
    $error("eg4_rst_seq: PWR_MS, SYS_MS, DEB_MS and SFT_US must all be non-zero");
  end

  rst_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .sys_clk_p (sys_clk_p),
    .pwr_rst_n (pwr_rst_n),
    .sys_us    (sys_us),
    .sys_ms    (sys_ms)
  );

  logic              btn_p0, btn_p1, btn_s, btn_d;
  logic [DEB_W-1:0]  deb_cnt;
  rst_state_e        state, state_nxt;
  logic              entry, entry_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              pwr_nxt, sys_nxt, rdy_nxt;

  assign btn_s = btn_p1 ^ BTN_POL;

  // Two-stage synchroniser for the raw button; resets to the released level.
  always_ff @(posedge sys_clk_p or negedge pwr_rst_n) begin
    if (!pwr_rst_n) begin
      btn_p0 <= BTN_POL;
      btn_p1 <= BTN_POL;
    end else begin
      btn_p0 <= ext_reset;
      btn_p1 <= btn_p0;
    end
  end

  // Debouncer: accept a new level after DEB_MS consecutive ms strobes of disagreement.
  always_ff @(posedge sys_clk_p or negedge pwr_rst_n) begin
    if (!pwr_rst_n) begin
      btn_d   <= 1'b0;
      deb_cnt <= '0;
    end else if (btn_s == btn_d) begin
      deb_cnt <= '0;
    end else if (sys_ms) begin
      if (deb_cnt == DEB_LAST) begin
        btn_d   <= btn_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Next state, hold counter and outputs; strobes on the entry cycle are ignored.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    if (entry) begin
      case (state)
        ST_PWR:  hold_nxt = HOLD_PWR;
        ST_SYS:  hold_nxt = HOLD_SYS;
        ST_SFT:  hold_nxt = HOLD_SFT;
        default: hold_nxt = '0;
      endcase
    end
    case (state)
      ST_PWR: begin
        if (btn_d) begin
          state_nxt = ST_BTN;
        end else if (!entry && sys_ms) begin
          if (hold_cnt == HOLD_ONE) state_nxt = ST_SYS;
          else                      hold_nxt  = hold_cnt - 1'b1;
        end
      end
      ST_SYS: begin
        if (btn_d) begin
          state_nxt = ST_BTN;
        end else if (!entry && sys_ms) begin
          if (hold_cnt == HOLD_ONE) state_nxt = ST_RUN;
          else                      hold_nxt  = hold_cnt - 1'b1;
        end
      end
      ST_RUN: begin
        if (btn_d)         state_nxt = ST_BTN;
        else if (cpu_srst) state_nxt = ST_SFT;
      end
      ST_SFT: begin
        if (btn_d) begin
          state_nxt = ST_BTN;
        end else if (!entry && sys_us) begin
          if (hold_cnt == HOLD_ONE) state_nxt = ST_RUN;
          else                      hold_nxt  = hold_cnt - 1'b1;
        end
      end
      ST_BTN: begin
        if (!btn_d) state_nxt = ST_PWR;
      end
      default: state_nxt = ST_PWR;
    endcase
    entry_nxt = (state_nxt != state);
    pwr_nxt   = (state_nxt == ST_PWR) || (state_nxt == ST_BTN);
    sys_nxt   = (state_nxt != ST_RUN);
    rdy_nxt   = (state_nxt == ST_RUN);
  end

  // State and registered reset outputs; reset holds both resets asserted.
  always_ff @(posedge sys_clk_p or negedge pwr_rst_n) begin
    if (!pwr_rst_n) begin
      state     <= ST_PWR;
      entry     <= 1'b1;
      hold_cnt  <= '0;
      pwr_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      sys_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      entry     <= entry_nxt;
      hold_cnt  <= hold_nxt;
      pwr_rst   <= pwr_nxt;
      sys_rst   <= sys_nxt;
      sys_ready <= rdy_nxt;
    end
  end

endmodule

// File: tb/tb_eg4_rst_seq.sv
// Directed bench for eg4_rst_seq with a 4 MHz clock (4 clocks per us, 4000 per ms).
module tb_eg4_rst_seq;

  logic sys_clk_p = 1'b0;
  logic pwr_rst_n = 1'b0;
  logic ext_reset = 1'b0;
  logic cpu_srst  = 1'b0;
  logic sys_us, sys_ms, pwr_rst, sys_rst, sys_ready;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 sys_clk_p = ~sys_clk_p;

  eg4_rst_seq #(
    .CLK_HZ (4000000),
    .PWR_MS (2),
    .SYS_MS (1),
    .DEB_MS (3),
    .SFT_US (5),
    .BTN_INV(0)
  ) dut (
    .sys_clk_p (sys_clk_p),
    .pwr_rst_n (pwr_rst_n),
    .ext_reset (ext_reset),
    .cpu_srst  (cpu_srst),
    .sys_us    (sys_us),
    .sys_ms    (sys_ms),
    .pwr_rst   (pwr_rst),
    .sys_rst   (sys_rst),
    .sys_ready (sys_ready)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // cyc = number of rising edges since reset release; strobes follow directly from it.
  task automatic tick();
    @(posedge sys_clk_p);
    cyc = cyc + 1;
    @(negedge sys_clk_p);
    chk("sys_us", sys_us, (cyc % 4) == 3);
    chk("sys_ms", sys_ms, (cyc % 4000) == 3999);
  endtask

  task automatic tick_exp(input logic ep, input logic es, input logic er);
    tick();
    chk("pwr_rst", pwr_rst, ep);
    chk("sys_rst", sys_rst, es);
    chk("sys_ready", sys_ready, er);
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_pwr_rst"}, pwr_rst, 1'b1);
    chk({tag, "_sys_rst"}, sys_rst, 1'b1);
    chk({tag, "_sys_us"}, sys_us, 1'b0);
    chk({tag, "_sys_ms"}, sys_ms, 1'b0);
    chk({tag, "_sys_ready"}, sys_ready, 1'b0);
  endtask

  // Drop the PLL lock for 3 clocks from a negedge, then release on a negedge.
  task automatic drop_rst(input string tag);
    pwr_rst_n = 1'b0;
    #1;
    chk_rst_vals(tag);
    repeat (3) begin
      @(posedge sys_clk_p);
      @(negedge sys_clk_p);
      chk_rst_vals(tag);
    end
    pwr_rst_n = 1'b1;
    cyc = 0;
  endtask

  // Full start-up sequence from release: PWR for 8000 clocks, SYS until 12000, then RUN.
  task automatic run_seq(input bit pulse_srst);
    while (cyc < 12000) begin
      cpu_srst = pulse_srst && (cyc == 100 || cyc == 9000);
      tick();
      chk("seq_pwr_rst", pwr_rst, cyc < 8000);
      chk("seq_sys_rst", sys_rst, cyc < 12000);
      chk("seq_sys_ready", sys_ready, cyc >= 12000);
    end
    cpu_srst = 1'b0;
  endtask

  initial begin
    int hi_cnt;
    int us_cnt;

    // Reset state while the PLL is unlocked.
    repeat (4) @(negedge sys_clk_p);
    chk_rst_vals("por");
    pwr_rst_n = 1'b1;
    cyc = 0;

    // Power-up sequence with soft-reset requests in PWR and SYS that must be ignored.
    run_seq(1'b1);

    // Soft reset from RUN: request at cyc 12099, SFT entered at 12100, exits at 12120.
    while (cyc < 12099) tick_exp(1'b0, 1'b0, 1'b1);
    cpu_srst = 1'b1;
    tick();
    cpu_srst = 1'b0;
    chk("sft_pwr_rst", pwr_rst, 1'b0);
    chk("sft_sys_rst", sys_rst, 1'b1);
    chk("sft_sys_ready", sys_ready, 1'b0);
    hi_cnt = 1;
    us_cnt = sys_us ? 1 : 0;
    for (int k = 0; k < 100 && sys_rst; k++) begin
      tick();
      chk("sft_pwr_low", pwr_rst, 1'b0);
      chk("sft_ready_inv", sys_ready, !sys_rst);
      if (sys_rst) begin
        hi_cnt++;
        if (sys_us) us_cnt++;
      end
    end
    chk("sft_released", sys_rst, 1'b0);
    chk_int("sft_us_strobes", us_cnt, 5);
    chk_int("sft_rst_cycles", hi_cnt, 20);
    chk_int("sft_exit_cycle", cyc, 12120);

    // PLL unlock while in SFT, then the sequence restarts from PWR.
    while (cyc < 12199) tick_exp(1'b0, 1'b0, 1'b1);
    cpu_srst = 1'b1;
    tick();
    cpu_srst = 1'b0;
    chk("sft2_sys_rst", sys_rst, 1'b1);
    tick_exp(1'b0, 1'b1, 1'b0);
    tick_exp(1'b0, 1'b1, 1'b0);
    drop_rst("unlock_sft");
    run_seq(1'b0);

    // Button bounce from cyc 12500 to 20500 (500-clock segments, starting pressed),
    // then held pressed: stable strobes at 23999/27999/31999, btn_d rises at edge 32000.
    while (cyc < 12500) tick_exp(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      ext_reset = (i % 2 == 0);
      repeat (500) tick_exp(1'b0, 1'b0, 1'b1);
    end
    ext_reset = 1'b1;
    while (cyc < 32000) tick_exp(1'b0, 1'b0, 1'b1);
    // Soft-reset request in the very cycle the debounced button goes high: button wins.
    cpu_srst = 1'b1;
    tick_exp(1'b1, 1'b1, 1'b0);
    cpu_srst = 1'b0;
    while (cyc < 33000) tick_exp(1'b1, 1'b1, 1'b0);

    // Release at 33000: btn_d falls at edge 44000, PWR entered at 44001, SYS at 52000.
    ext_reset = 1'b0;
    while (cyc < 51999) tick_exp(1'b1, 1'b1, 1'b0);
    tick_exp(1'b0, 1'b1, 1'b0);
    while (cyc < 52100) tick_exp(1'b0, 1'b1, 1'b0);

    // PLL unlock while in SYS; sequence restarts in PWR.
    drop_rst("unlock_sys");
    while (cyc < 1000) tick_exp(1'b1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
